// File: rtl/cdb_pkg.sv
// Common data bus shared definitions: default widths, opcode encodings and
// instruction field positions for imm[15:10] Rx[9:7] Ry[6:4] opcode[3:0].
package cdb_pkg;

  localparam int unsigned DEF_DATA_W = 16;
  localparam int unsigned DEF_INST_W = 16;
  localparam int unsigned DEF_TAG_W  = 3;

  localparam int unsigned OP_W = 4;
  localparam logic [OP_W-1:0] OP_ADD = 4'b0000;
  localparam logic [OP_W-1:0] OP_SUB = 4'b0001;
  localparam logic [OP_W-1:0] OP_LD  = 4'b0010;
  localparam logic [OP_W-1:0] OP_SD  = 4'b0011;
  localparam logic [OP_W-1:0] OP_MUL = 4'b0100;

  localparam int unsigned IMM_MSB = 15;
  localparam int unsigned IMM_LSB = 10;
  localparam int unsigned RX_MSB  = 9;
  localparam int unsigned RX_LSB  = 7;
  localparam int unsigned RY_MSB  = 6;
  localparam int unsigned RY_LSB  = 4;
  localparam int unsigned RD_MSB  = RX_MSB;
  localparam int unsigned RD_LSB  = RX_LSB;
  localparam int unsigned OP_MSB  = 3;
  localparam int unsigned OP_LSB  = 0;

  // True for opcodes whose result is written back to the register file.
  function automatic logic is_reg_write(input logic [OP_W-1:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_LD) || (op == OP_MUL);
  endfunction

endpackage

// File: rtl/cdb_broadcaster_rr_arbiter.sv
// Combinational round-robin arbiter: first request strictly after ptr_i,
// wrapping from NUM_SRC-1 back to 0.
module rr_arbiter #(
  parameter int unsigned NUM_SRC = 4,
  parameter int unsigned SRC_W   = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req_i,
  input  logic [SRC_W-1:0]   ptr_i,
  output logic [NUM_SRC-1:0] grant_o,
  output logic [SRC_W-1:0]   grant_idx_o,
  output logic               any_o
);

  int unsigned idx;

  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    any_o       = 1'b0;
    idx         = 0;
    for (int unsigned k = 1; k <= NUM_SRC; k++) begin
      idx = (32'(ptr_i) + k) % NUM_SRC;
      if (!any_o && req_i[SRC_W'(idx)]) begin
        any_o                 = 1'b1;
        grant_o[SRC_W'(idx)]  = 1'b1;
        grant_idx_o           = SRC_W'(idx);
      end
    end
  end

endmodule

// File: rtl/cdb_broadcaster.sv
// Producer end of the common data bus: one holding slot per source and a
// round-robin grant that broadcasts at most one result per cycle.
module cdb_broadcaster
  import cdb_pkg::*;
#(
  parameter int unsigned NUM_SRC = 4,
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned INST_W  = DEF_INST_W,
  parameter int unsigned TAG_W   = DEF_TAG_W
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_SRC-1:0]         src_valid,
  output logic [NUM_SRC-1:0]         src_ready,
  input  logic [NUM_SRC*DATA_W-1:0]  src_data,
  input  logic [NUM_SRC*INST_W-1:0]  src_inst,
  input  logic [NUM_SRC*TAG_W-1:0]   src_tag,
  input  logic                       cdb_stall,
  output logic                       cdb_valid,
  output logic [DATA_W-1:0]          cdb_data,
  output logic [INST_W-1:0]          cdb_inst,
  output logic [TAG_W-1:0]           cdb_tag,
  output logic [$clog2(NUM_SRC)-1:0] cdb_src,
  output logic                       cdb_wr_reg
);

  localparam int unsigned SRC_W = $clog2(NUM_SRC);

  logic [NUM_SRC-1:0] held_q, held_d;
  logic [NUM_SRC-1:0] ready_q, ready_d;
  logic [NUM_SRC-1:0] take, grant;
  logic [DATA_W-1:0]  slot_data_q [NUM_SRC];
  logic [DATA_W-1:0]  slot_data_d [NUM_SRC];
  logic [INST_W-1:0]  slot_inst_q [NUM_SRC];
  logic [INST_W-1:0]  slot_inst_d [NUM_SRC];
  logic [TAG_W-1:0]   slot_tag_q  [NUM_SRC];
  logic [TAG_W-1:0]   slot_tag_d  [NUM_SRC];
  logic [SRC_W-1:0]   ptr_q, ptr_d, gnt_idx;
  logic               gnt_any, fire;

  logic               valid_q, valid_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [INST_W-1:0]  inst_q, inst_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic [SRC_W-1:0]   src_q, src_d;
  logic               wr_reg_q, wr_reg_d;

  rr_arbiter #(.NUM_SRC(NUM_SRC), .SRC_W(SRC_W)) u_arb (
    .req_i       (held_q),
    .ptr_i       (ptr_q),
    .grant_o     (grant),
    .grant_idx_o (gnt_idx),
    .any_o       (gnt_any)
  );

  assign take = src_valid & ready_q;
  assign fire = gnt_any & ~cdb_stall;

  // Capture into free slots, then retire the granted slot onto the bus.
  always_comb begin
    held_d      = held_q;
    slot_data_d = slot_data_q;
    slot_inst_d = slot_inst_q;
    slot_tag_d  = slot_tag_q;
    ptr_d       = ptr_q;
    valid_d     = 1'b0;
    data_d      = data_q;
    inst_d      = inst_q;
    tag_d       = tag_q;
    src_d       = src_q;
    wr_reg_d    = wr_reg_q;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (take[i]) begin
        slot_data_d[i] = src_data[i*DATA_W +: DATA_W];
        slot_inst_d[i] = src_inst[i*INST_W +: INST_W];
        slot_tag_d[i]  = src_tag[i*TAG_W +: TAG_W];
        held_d[i]      = 1'b1;
      end
    end
    if (fire) begin
      held_d   = held_d & ~grant;
      ptr_d    = gnt_idx;
      valid_d  = 1'b1;
      data_d   = slot_data_q[gnt_idx];
      inst_d   = slot_inst_q[gnt_idx];
      tag_d    = slot_tag_q[gnt_idx];
      src_d    = gnt_idx;
      wr_reg_d = is_reg_write(slot_inst_q[gnt_idx][OP_MSB:OP_LSB]);
    end
    ready_d = ~held_d;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      held_q   <= '0;
      ready_q  <= '1;
      ptr_q    <= SRC_W'(NUM_SRC - 1);
      valid_q  <= 1'b0;
      data_q   <= '0;
      inst_q   <= '0;
      tag_q    <= '0;
      src_q    <= '0;
      wr_reg_q <= 1'b0;
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
        slot_data_q[i] <= '0;
        slot_inst_q[i] <= '0;
        slot_tag_q[i]  <= '0;
      end
    end else begin
      held_q      <= held_d;
      ready_q     <= ready_d;
      ptr_q       <= ptr_d;
      valid_q     <= valid_d;
      data_q      <= data_d;
      inst_q      <= inst_d;
      tag_q       <= tag_d;
      src_q       <= src_d;
      wr_reg_q    <= wr_reg_d;
      slot_data_q <= slot_data_d;
      slot_inst_q <= slot_inst_d;
      slot_tag_q  <= slot_tag_d;
    end
  end

  assign src_ready  = ready_q;
  assign cdb_valid  = valid_q;
  assign cdb_data   = data_q;
  assign cdb_inst   = inst_q;
  assign cdb_tag    = tag_q;
  assign cdb_src    = src_q;
  assign cdb_wr_reg = wr_reg_q;

endmodule

// File: tb/tb_cdb_broadcaster.sv
// Directed bench for cdb_broadcaster: reset, single result, round-robin order,
// stall, store write-enable and producer backpressure.
module tb_cdb_broadcaster;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  src_valid;
  logic [3:0]  src_ready;
  logic [63:0] src_data;
  logic [63:0] src_inst;
  logic [11:0] src_tag;
  logic        cdb_stall;
  logic        cdb_valid;
  logic [15:0] cdb_data;
  logic [15:0] cdb_inst;
  logic [2:0]  cdb_tag;
  logic [1:0]  cdb_src;
  logic        cdb_wr_reg;

  int tests_run    = 0;
  int tests_failed = 0;

  cdb_broadcaster dut (
    .clock      (clock),
    .reset      (reset),
    .src_valid  (src_valid),
    .src_ready  (src_ready),
    .src_data   (src_data),
    .src_inst   (src_inst),
    .src_tag    (src_tag),
    .cdb_stall  (cdb_stall),
    .cdb_valid  (cdb_valid),
    .cdb_data   (cdb_data),
    .cdb_inst   (cdb_inst),
    .cdb_tag    (cdb_tag),
    .cdb_src    (cdb_src),
    .cdb_wr_reg (cdb_wr_reg)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_src(input int i, input logic [15:0] d, input logic [15:0] ins,
                         input logic [2:0] t);
    src_data[i*16 +: 16] = d;
    src_inst[i*16 +: 16] = ins;
    src_tag[i*3 +: 3]    = t;
  endtask

  task automatic expect_bcast(input string tag, input logic [1:0] s, input logic [15:0] d,
                              input logic [2:0] t, input logic wr);
    check({tag, "_valid"}, 32'(cdb_valid), 32'd1);
    check({tag, "_src"},   32'(cdb_src),   32'(s));
    check({tag, "_data"},  32'(cdb_data),  32'(d));
    check({tag, "_tag"},   32'(cdb_tag),   32'(t));
    check({tag, "_wr"},    32'(cdb_wr_reg), 32'(wr));
  endtask

  initial begin
    reset     = 1'b1;
    src_valid = '0;
    src_data  = '0;
    src_inst  = '0;
    src_tag   = '0;
    cdb_stall = 1'b0;

    // Reset state
    tick();
    check("rst_valid", 32'(cdb_valid), 32'd0);
    check("rst_ready", 32'(src_ready), 32'hf);
    check("rst_data",  32'(cdb_data),  32'd0);
    check("rst_src",   32'(cdb_src),   32'd0);
    check("rst_wr",    32'(cdb_wr_reg), 32'd0);
    #1 reset = 1'b0;

    // Single result from src0
    set_src(0, 16'h0042, 16'h0400, 3'd1);
    src_valid = 4'b0001;
    tick();
    src_valid = '0;
    check("single_lat_valid", 32'(cdb_valid), 32'd0);
    check("single_ready", 32'(src_ready), 32'b1110);
    tick();
    expect_bcast("single", 2'd0, 16'h0042, 3'd1, 1'b1);
    check("single_inst", 32'(cdb_inst), 32'h0400);
    check("single_ready_free", 32'(src_ready), 32'hf);
    tick();
    check("single_after_valid", 32'(cdb_valid), 32'd0);
    check("single_after_data", 32'(cdb_data), 32'h0042);

    // Async reset mid-cycle with three held slots
    cdb_stall = 1'b1;
    for (int i = 1; i < 4; i++) set_src(i, 16'(16'h0100 + i), 16'h0000, 3'(i));
    src_valid = 4'b1110;
    tick();
    src_valid = '0;
    check("held3_ready", 32'(src_ready), 32'b0001);
    #3 reset = 1'b1;
    #1;
    check("async_rst_valid", 32'(cdb_valid), 32'd0);
    check("async_rst_ready", 32'(src_ready), 32'hf);
    check("async_rst_data",  32'(cdb_data),  32'd0);
    cdb_stall = 1'b0;
    #2 reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post_rst_no_bcast", 32'(cdb_valid), 32'd0);
    end

    // Round robin: all four at once, then refill src0 and src2
    set_src(0, 16'h0001, 16'h0000, 3'd4);
    set_src(1, 16'h0002, 16'h0001, 3'd5);
    set_src(2, 16'h0003, 16'h0002, 3'd6);
    set_src(3, 16'h0004, 16'h0004, 3'd7);
    src_valid = 4'b1111;
    tick();
    src_valid = '0;
    check("rr_cap_valid", 32'(cdb_valid), 32'd0);
    check("rr_cap_ready", 32'(src_ready), 32'b0000);
    tick(); expect_bcast("rr0", 2'd0, 16'h0001, 3'd4, 1'b1);
    tick(); expect_bcast("rr1", 2'd1, 16'h0002, 3'd5, 1'b1);
    tick(); expect_bcast("rr2", 2'd2, 16'h0003, 3'd6, 1'b1);
    tick(); expect_bcast("rr3", 2'd3, 16'h0004, 3'd7, 1'b1);
    set_src(0, 16'h0010, 16'h0000, 3'd0);
    set_src(2, 16'h0030, 16'h0001, 3'd2);
    src_valid = 4'b0101;
    tick();
    src_valid = '0;
    check("refill_cap_valid", 32'(cdb_valid), 32'd0);
    tick(); expect_bcast("refill0", 2'd0, 16'h0010, 3'd0, 1'b1);
    tick(); expect_bcast("refill2", 2'd2, 16'h0030, 3'd2, 1'b1);
    tick();
    check("refill_idle", 32'(cdb_valid), 32'd0);

    // Stall with src1 and src3 held; pointer sits at 2 so src3 goes first
    cdb_stall = 1'b1;
    set_src(1, 16'h00a1, 16'h0004, 3'd1);
    set_src(3, 16'h00a3, 16'h0002, 3'd3);
    src_valid = 4'b1010;
    tick();
    src_valid = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_valid", 32'(cdb_valid), 32'd0);
      check("stall_data",  32'(cdb_data),  32'h0030);
      check("stall_src",   32'(cdb_src),   32'd2);
      check("stall_ready", 32'(src_ready), 32'b0101);
    end
    cdb_stall = 1'b0;
    tick(); expect_bcast("unstall_a", 2'd3, 16'h00a3, 3'd3, 1'b1);
    tick(); expect_bcast("unstall_b", 2'd1, 16'h00a1, 3'd1, 1'b1);
    tick();
    check("unstall_idle", 32'(cdb_valid), 32'd0);
    check("unstall_ready", 32'(src_ready), 32'hf);

    // Store does not write the register file
    set_src(3, 16'h0010, 16'h0003, 3'd2);
    src_valid = 4'b1000;
    tick();
    src_valid = '0;
    tick(); expect_bcast("store", 2'd3, 16'h0010, 3'd2, 1'b0);

    // Backpressure: src1 held valid for four stalled edges, one capture only
    cdb_stall = 1'b1;
    set_src(1, 16'h00b1, 16'h0085, 3'd5);
    src_valid = 4'b0010;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("bp_ready", 32'(src_ready), 32'b1101);
      check("bp_valid", 32'(cdb_valid), 32'd0);
    end
    src_valid = '0;
    cdb_stall = 1'b0;
    tick(); expect_bcast("bp", 2'd1, 16'h00b1, 3'd5, 1'b0);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("bp_no_dup", 32'(cdb_valid), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
